// File: rtl/rob_param.sv
`default_nettype none
// ============================================================================
// Module   : rob_param
// Purpose  : Parametrised reorder buffer for the Tomasulo core. Entries are
//            allocated in program order at dispatch. Results are captured
//            from NCDB common-data-bus channels. Completed entries commit in
//            order, one per cycle, to the register file. Completed but not yet
//            committed values are forwarded to dispatch. A synchronous Flush
//            squashes every entry for mispredict recovery.
// Ports    : CLK, Reset (async, active-high), Flush
//            append/DestReg               - allocate at tail
//            full/empty/count/ROBTail/ROBHead - occupancy and pointers
//            CDB/CDB_WB                   - NCDB result channels + WB flags
//            WA/WE/WD                     - commit port to the register file
//            IndexA/B, ForwardA/B, ForwardDataA/B - forwarding lookups
// Revision : 1.0 - initial release
// ============================================================================
module rob_param #(
  parameter  int DEPTH = 8,
  parameter  int NCDB  = 4,
  parameter  int DW    = 32,
  parameter  int RW    = 4,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = DW + 1 + IW
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Flush,
  input  logic               append,
  input  logic [RW-1:0]      DestReg,
  output logic               full,
  output logic               empty,
  output logic [IW:0]        count,
  output logic [IW-1:0]      ROBTail,
  output logic [IW-1:0]      ROBHead,
  input  logic [NCDB*CW-1:0] CDB,
  input  logic [NCDB-1:0]    CDB_WB,
  output logic [RW-1:0]      WA,
  output logic               WE,
  output logic [DW-1:0]      WD,
  input  logic [IW-1:0]      IndexA,
  input  logic [IW-1:0]      IndexB,
  output logic               ForwardA,
  output logic               ForwardB,
  output logic [DW-1:0]      ForwardDataA,
  output logic [DW-1:0]      ForwardDataB
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IW:0]       r_head;
  logic [IW:0]       r_tail;
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_done;
  logic [RW-1:0]     r_dest  [DEPTH];
  logic [DW-1:0]     r_value [DEPTH];
  logic [DEPTH-1:0]  r_wb;

  logic [IW-1:0]     w_head_idx;
  logic [IW-1:0]     w_tail_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_append;
  logic              w_commit;

  logic [IW-1:0]     w_cdb_tag  [NCDB];
  logic              w_cdb_vld  [NCDB];
  logic [DW-1:0]     w_cdb_data [NCDB];

  logic [DEPTH-1:0]  w_cap;
  logic [DW-1:0]     w_cap_data [DEPTH];
  logic [DEPTH-1:0]  w_cap_wb;

  logic [DEPTH-1:0]  w_busy_nxt;
  logic [DEPTH-1:0]  w_done_nxt;

  // --------------------------------------------------------------------------
  // Channel slicing
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NCDB; c++) begin : g_ch
    assign w_cdb_tag[c]  = CDB[c*CW +: IW];
    assign w_cdb_vld[c]  = CDB[c*CW + IW];
    assign w_cdb_data[c] = CDB[c*CW + IW + 1 +: DW];
  end

  // --------------------------------------------------------------------------
  // Status
  // --------------------------------------------------------------------------
  assign w_head_idx = r_head[IW-1:0];
  assign w_tail_idx = r_tail[IW-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IW] != r_tail[IW]);

  // full is taken from the pre-commit state, so a full ROB drops an append
  // even when the head retires in the same cycle.
  assign w_append   = append && !w_full && !Flush;
  assign w_commit   = !w_empty && r_done[w_head_idx] && !Flush;

  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_tail - r_head;
  assign ROBHead    = w_head_idx;
  assign ROBTail    = w_tail_idx;

  // --------------------------------------------------------------------------
  // CDB capture. Channels are scanned in ascending order so the
  // highest-numbered channel carrying a given tag overrides the others.
  // Only busy, not-yet-done entries accept a result; an entry being appended
  // this cycle is not yet busy and therefore ignores the bus.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_cap[i]      = 1'b0;
      w_cap_data[i] = '0;
      w_cap_wb[i]   = 1'b0;
      for (int c = 0; c < NCDB; c++) begin
        if (w_cdb_vld[c] && (w_cdb_tag[c] == IW'(i)) && r_busy[i] && !r_done[i]) begin
          w_cap[i]      = 1'b1;
          w_cap_data[i] = w_cdb_data[c];
          w_cap_wb[i]   = CDB_WB[c];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state for the per-entry status bits. The commit slot and append slot
  // never coincide: an empty ROB cannot commit and a full one cannot append.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = r_busy;
    w_done_nxt = r_done | w_cap;
    if (w_commit) begin
      w_busy_nxt[w_head_idx] = 1'b0;
      w_done_nxt[w_head_idx] = 1'b0;
    end
    if (w_append) begin
      w_busy_nxt[w_tail_idx] = 1'b1;
      w_done_nxt[w_tail_idx] = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else if (Flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_commit) r_head <= r_head + 1'b1;
      if (w_append) r_tail <= r_tail + 1'b1;
    end
  end

  // Payload storage is not reset; BUSY/DONE qualify every use of it.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!Flush && w_cap[i]) begin
        r_value[i] <= w_cap_data[i];
        r_wb[i]    <= w_cap_wb[i];
      end
      if (w_append && (w_tail_idx == IW'(i))) begin
        r_dest[i] <= DestReg;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Commit port: zero whenever nothing retires this cycle.
  // --------------------------------------------------------------------------
  assign WE = w_commit & r_wb[w_head_idx];
  assign WA = w_commit ? r_dest[w_head_idx]  : '0;
  assign WD = w_commit ? r_value[w_head_idx] : '0;

  // --------------------------------------------------------------------------
  // Forwarding: data is presented regardless of the hit flag.
  // --------------------------------------------------------------------------
  assign ForwardA     = r_busy[IndexA] & r_done[IndexA];
  assign ForwardB     = r_busy[IndexB] & r_done[IndexB];
  assign ForwardDataA = r_value[IndexA];
  assign ForwardDataB = r_value[IndexB];

endmodule
`default_nettype wire

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer for the Tomasulo core: allocates entries in program order at dispatch and captures results from any number of CDB channels. It commits completed entries in order to the register file, one per cycle, and forwards completed-but-uncommitted values to dispatch. It adds four things to the fixed 8-entry/4-channel ROB: configurable depth and channel count, per-channel writeback flags, a synchronous flush for mispredict recovery, and occupancy/empty outputs.

## Interface
- DEPTH, 8: entries; power of two, ≥2. IW = log2(DEPTH).
- NCDB, 4: CDB channels.
- DW, 32: result width.
- RW, 4: architectural register index width.
- CW (derived) = DW+1+IW: channel slice width.
- CLK  in  1  clock, rising edge.
- Reset  in  1  reset; asynchronous, active-high.
- Flush  in  1  synchronous squash of all entries.
- append  in  1  allocate entry at tail with DestReg.
- DestReg  in  RW  destination register of appended instruction.
- full  out  1  DEPTH entries occupied.
- empty  out  1  no entries occupied.
- count  out  IW+1  occupancy, 0..DEPTH.
- ROBTail  out  IW  index the next append receives.
- ROBHead  out  IW  index of oldest entry.
- CDB  in  NCDB*CW  channel c = CDB[c*CW +: CW]; slice[IW-1:0] tag, slice[IW] valid, slice[CW-1:IW+1] data.
- CDB_WB  in  NCDB  per channel: result writes the register file on commit.
- WA  out  RW  commit register address.
- WE  out  1  commit write enable.
- WD  out  DW  commit data.
- IndexA, IndexB  in  IW  forwarding lookup tags.
- ForwardA, ForwardB  out  1  looked-up entry busy and completed.
- ForwardDataA, ForwardDataB  out  DW  stored value of looked-up entry.

## Operation
- Pointers head, tail are IW+1 bits (wrap bit). empty = (head==tail). full = (head[IW-1:0]==tail[IW-1:0]) && wrap bits differ. count = tail−head mod 2^(IW+1). ROBHead/ROBTail = low IW bits.
- Per entry: BUSY, DONE, DEST[RW], VALUE[DW], WB.
- Append: if append && !full && !Flush: BUSY[tail]=1, DONE[tail]=0, DEST[tail]=DestReg, tail+=1. Append while full is dropped; tail, count and state are unchanged.
- CDB capture: for each channel c with valid=1 and BUSY[tag]=1 and DONE[tag]=0: DONE=1, VALUE=data, WB=CDB_WB[c].
  - Valid data to a non-busy or already-done entry is ignored. This covers the entry being allocated in the same cycle.
  - Two channels with the same tag in one cycle: the highest-numbered channel wins.
- Commit: commit = !empty && DONE[head] && !Flush. While commit is high, WA=DEST[head], WE=WB[head], WD=VALUE[head] (combinational). At the edge, BUSY[head]=0 and head+=1. When commit is low, WA=0, WE=0, WD=0.
  - A commit with WB=0 (e.g. a store) retires with WE=0.
- Append and commit in the same cycle: both take effect and count is unchanged.
  - full is evaluated before the commit. A full ROB with a commit in the same cycle still drops the append.
- Forwarding (combinational): ForwardX = BUSY[IndexX] & DONE[IndexX]; ForwardDataX = VALUE[IndexX] regardless of ForwardX. A value captured this cycle is visible from the next cycle.
- Flush (synchronous, priority over append/CDB/commit): all BUSY=0, all DONE=0, head=tail=0. WE is forced 0 in the Flush cycle.

## Timing
- Reset asynchronous: head=tail=0, BUSY=DONE=0. Immediately after reset: empty=1, full=0, count=0, ROBHead=ROBTail=0, WE=0, WA=0, WD=0, ForwardA=ForwardB=0. VALUE/DEST/WB are not reset.
- Reset asserted mid-operation discards all entries at once; no commit occurs.
- Append→visible in ROBTail/count: 1 cycle.
- CDB capture→commit eligible: next cycle, provided the entry is at head. Minimum latency is append at cycle 0, CDB at cycle 1, WE at cycle 2.
- Throughput: 1 append and 1 commit per cycle.
- Pointer wrap: index DEPTH−1 is followed by index 0, and the wrap bit toggles.

## Test plan
- Reset then idle: empty=1, count=0, WE=0 for 10 cycles. Assert Reset mid-fill with 3 entries: count=0 on the same edge.
- DEPTH=8: append 8 with DestReg 1..8 -> full=1, count=8. A 9th append is dropped, so ROBTail stays 0.
  - Then CDB ch0 tags 0..7 with data 0x100+i and WB=1 -> WE on 8 consecutive cycles, WA=1..8, WD=0x100..0x107, then empty=1.
- Out-of-order completion: append 3, CDB tag2 then tag1 then tag0 on ch3/ch1/ch0 -> no WE until tag0 arrives. Then 3 commits in order, WA/WD matching.
- Channel conflict: ch0 and ch2 both write tag 0 in one cycle with 0xAAAA/0xBBBB -> WD=0xBBBB. A CDB to an unallocated tag 5 -> ForwardA (IndexA=5) stays 0.
- Forwarding and WB flag: CDB tag1 with data 0x1234 and CDB_WB=0 -> ForwardA=1 and ForwardDataA=0x1234 next cycle. Its commit shows WE=0 and head advances.
- Flush with 5 entries, 2 of them done at head -> WE=0 in that cycle. Next cycle empty=1, ROBHead=ROBTail=0, ForwardA=0. An append immediately after flush lands at index 0.
